// File: rtl/alu_arbiter_pkg.sv
//==============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared ALU opcode set and operand bundle type.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package alu_arbiter_pkg;

    localparam int DATA_W   = 16;
    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP    = 4'd0,
        OP_ADD    = 4'd1,
        OP_SUB    = 4'd2,
        OP_AND    = 4'd3,
        OP_OR     = 4'd4,
        OP_XOR    = 4'd5,
        OP_SHIFT  = 4'd6,
        OP_MOVE   = 4'd7,
        OP_LOAD   = 4'd8,
        OP_STORE  = 4'd9,
        OP_JUMP   = 4'd10,
        OP_LOADC  = 4'd11,
        OP_OUT    = 4'd12,
        OP_UNDEF3 = 4'd13,
        OP_UNDEF4 = 4'd14,
        OP_HALT   = 4'd15
    } opcode_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic                shift_dir;
        logic [DATA_W-1:0]   data1;
        logic [DATA_W-1:0]   data2;
    } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
//==============================================================================
// Module      : alu_arbiter_alu
// Description : Combinational 16-bit ALU; opcodes without a result give zero.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_shift_dir,
    input  logic [DATA_W-1:0]   i_data1,
    input  logic [DATA_W-1:0]   i_data2,
    output logic [DATA_W-1:0]   o_result
);

    always_comb begin
        o_result = '0;
        case (i_opcode)
            OP_ADD:  o_result = i_data1 + i_data2;
            OP_SUB:  o_result = i_data1 - i_data2;
            OP_AND:  o_result = i_data1 & i_data2;
            OP_OR:   o_result = i_data1 | i_data2;
            OP_XOR:  o_result = i_data1 ^ i_data2;
            OP_MOVE: o_result = i_data1;
            OP_SHIFT: begin
                // Any amount of 16 or more shifts every bit out.
                if (i_data2[DATA_W-1:4] != '0) begin
                    o_result = '0;
                end else if (i_shift_dir) begin
                    o_result = i_data1 << i_data2[3:0];
                end else begin
                    o_result = i_data1 >> i_data2[3:0];
                end
            end
            default: o_result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
//==============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin front end sharing one registered ALU.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req0_valid,
    output logic                o_req0_ready,
    input  logic [OPCODE_W-1:0] i_req0_opcode,
    input  logic                i_req0_shift_dir,
    input  logic [DATA_W-1:0]   i_req0_data1,
    input  logic [DATA_W-1:0]   i_req0_data2,
    input  logic                i_req1_valid,
    output logic                o_req1_ready,
    input  logic [OPCODE_W-1:0] i_req1_opcode,
    input  logic                i_req1_shift_dir,
    input  logic [DATA_W-1:0]   i_req1_data1,
    input  logic [DATA_W-1:0]   i_req1_data2,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic                o_rsp_id,
    output logic [DATA_W-1:0]   o_rsp_data,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic c_ID0 = 1'b0;
    localparam logic c_ID1 = 1'b1;

    state_e              r_state_q, w_state_d;
    logic                r_last_q, w_last_d;
    alu_op_t             r_op_q, w_op_d;
    logic                r_id_q, w_id_d;
    logic [DATA_W-1:0]   r_rsp_data_q, w_rsp_data_d;
    logic                r_rsp_id_q, w_rsp_id_d;
    logic                w_grant_vld;
    logic                w_grant_id;
    logic [DATA_W-1:0]   w_alu_result;
    alu_op_t             w_req0_op, w_req1_op;

    assign w_req0_op = '{i_req0_opcode, i_req0_shift_dir, i_req0_data1, i_req0_data2};
    assign w_req1_op = '{i_req1_opcode, i_req1_shift_dir, i_req1_data1, i_req1_data2};

    // Grant is suppressed during reset so no transfer can coincide with it.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = c_ID0;
        if ((r_state_q == IDLE) && !i_reset) begin
            if (i_req0_valid && i_req1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = ~r_last_q;
            end else if (i_req0_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = c_ID0;
            end else if (i_req1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = c_ID1;
            end
        end
    end

    assign o_req0_ready = w_grant_vld && (w_grant_id == c_ID0);
    assign o_req1_ready = w_grant_vld && (w_grant_id == c_ID1);

    always_comb begin
        w_state_d    = r_state_q;
        w_last_d     = r_last_q;
        w_op_d       = r_op_q;
        w_id_d       = r_id_q;
        w_rsp_data_d = r_rsp_data_q;
        w_rsp_id_d   = r_rsp_id_q;
        case (r_state_q)
            IDLE: begin
                if (w_grant_vld) begin
                    w_state_d = EXEC;
                    w_id_d    = w_grant_id;
                    w_op_d    = (w_grant_id == c_ID1) ? w_req1_op : w_req0_op;
                end
            end
            EXEC: begin
                w_rsp_data_d = w_alu_result;
                w_rsp_id_d   = r_id_q;
                w_state_d    = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    w_last_d  = r_rsp_id_q;
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Last-grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q    <= IDLE;
            r_last_q     <= c_ID1;
            r_op_q       <= '0;
            r_id_q       <= c_ID0;
            r_rsp_data_q <= '0;
            r_rsp_id_q   <= c_ID0;
        end else begin
            r_state_q    <= w_state_d;
            r_last_q     <= w_last_d;
            r_op_q       <= w_op_d;
            r_id_q       <= w_id_d;
            r_rsp_data_q <= w_rsp_data_d;
            r_rsp_id_q   <= w_rsp_id_d;
        end
    end

    alu_arbiter_alu u_alu (
        .i_opcode    (r_op_q.opcode),
        .i_shift_dir (r_op_q.shift_dir),
        .i_data1     (r_op_q.data1),
        .i_data2     (r_op_q.data2),
        .o_result    (w_alu_result)
    );

    assign o_rsp_valid = (r_state_q == RESP);
    assign o_rsp_data  = r_rsp_data_q;
    assign o_rsp_id    = r_rsp_id_q;
    assign o_busy      = (r_state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//==============================================================================
// Module      : tb_alu_arbiter
// Description : Scenario tasks plus a scoreboard fed on transfers, drained on responses.
// Revision    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req0_valid = 1'b0, i_req1_valid = 1'b0;
    logic        o_req0_ready, o_req1_ready;
    logic [3:0]  i_req0_opcode = '0, i_req1_opcode = '0;
    logic        i_req0_shift_dir = 1'b0, i_req1_shift_dir = 1'b0;
    logic [15:0] i_req0_data1 = '0, i_req0_data2 = '0;
    logic [15:0] i_req1_data1 = '0, i_req1_data2 = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b1;
    logic        o_rsp_id;
    logic [15:0] o_rsp_data;
    logic        o_busy;

    typedef struct packed {
        logic        id;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 i_clk = ~i_clk;

    alu_arbiter dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_req0_valid     (i_req0_valid),
        .o_req0_ready     (o_req0_ready),
        .i_req0_opcode    (i_req0_opcode),
        .i_req0_shift_dir (i_req0_shift_dir),
        .i_req0_data1     (i_req0_data1),
        .i_req0_data2     (i_req0_data2),
        .i_req1_valid     (i_req1_valid),
        .o_req1_ready     (o_req1_ready),
        .i_req1_opcode    (i_req1_opcode),
        .i_req1_shift_dir (i_req1_shift_dir),
        .i_req1_data1     (i_req1_data1),
        .i_req1_data2     (i_req1_data2),
        .o_rsp_valid      (o_rsp_valid),
        .i_rsp_ready      (i_rsp_ready),
        .o_rsp_id         (o_rsp_id),
        .o_rsp_data       (o_rsp_data),
        .o_busy           (o_busy)
    );

    function automatic logic [15:0] model(input logic [3:0] op, input logic dir,
                                          input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        r = 16'h0000;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_MOVE:  r = a;
            OP_SHIFT: begin
                if (b >= 16'd16) r = 16'h0000;
                else if (dir)    r = a << b;
                else             r = a >> b;
            end
            default:  r = 16'h0000;
        endcase
        return r;
    endfunction

    // Scoreboard: push on each transfer, pop on each response handshake.
    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (o_req0_ready || o_req1_ready) begin
                n_tests++;
                if (o_req0_ready && o_req1_ready) begin
                    n_fail++;
                    $display("FAIL ready_exclusive: ready0=%b ready1=%b, required not both high", o_req0_ready, o_req1_ready);
                end
            end
            if (o_req0_ready && i_req0_valid)
                sb_q.push_back('{1'b0, model(i_req0_opcode, i_req0_shift_dir, i_req0_data1, i_req0_data2)});
            if (o_req1_ready && i_req1_valid)
                sb_q.push_back('{1'b1, model(i_req1_opcode, i_req1_shift_dir, i_req1_data1, i_req1_data2)});
            if (o_rsp_valid && i_rsp_ready) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got id=%0d data=%h, required no response", o_rsp_id, o_rsp_data);
                end else begin
                    sb_e = sb_q.pop_front();
                    if ({o_rsp_id, o_rsp_data} !== {sb_e.id, sb_e.data}) begin
                        n_fail++;
                        $display("FAIL sb_rsp: got id=%0d data=%h, required id=%0d data=%h",
                                 o_rsp_id, o_rsp_data, sb_e.id, sb_e.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic send(input logic id, input logic [3:0] op, input logic dir,
                        input logic [15:0] d1, input logic [15:0] d2);
        logic ok;
        ok = 1'b0;
        step();
        if (id) begin
            i_req1_valid = 1'b1; i_req1_opcode = op; i_req1_shift_dir = dir;
            i_req1_data1 = d1;   i_req1_data2 = d2;
        end else begin
            i_req0_valid = 1'b1; i_req0_opcode = op; i_req0_shift_dir = dir;
            i_req0_data1 = d1;   i_req0_data2 = d2;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (id ? o_req1_ready : o_req0_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_grant: requester %0d got no ready within 20 cycles, required a grant", id);
        end
        step();
        if (id) i_req1_valid = 1'b0;
        else    i_req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        step();
        step();
        @(negedge i_clk);
        n_tests++;
        if ({o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_busy} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_state: r0=%b r1=%b vld=%b id=%b data=%h busy=%b, required all zero",
                     o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_busy);
        end
        step();
        i_reset = 1'b0;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        @(negedge i_clk);
        n_tests++;
        if ({o_busy, o_rsp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b vld=%b, required 0 0", o_busy, o_rsp_valid);
        end
    endtask

    task automatic test_add();
        i_rsp_ready = 1'b1;
        step();
        i_req0_valid = 1'b1; i_req0_opcode = OP_ADD; i_req0_shift_dir = 1'b0;
        i_req0_data1 = 16'h0003; i_req0_data2 = 16'h0004;
        @(negedge i_clk);
        n_tests++;
        if ({o_req0_ready, o_req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL add_accept: ready0=%b ready1=%b, required 1 0", o_req0_ready, o_req1_ready);
        end
        step();
        i_req0_valid = 1'b0;
        @(negedge i_clk);
        n_tests++;
        if ({o_rsp_valid, o_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL add_exec: vld=%b busy=%b, required 0 1", o_rsp_valid, o_busy);
        end
        step();
        @(negedge i_clk);
        n_tests++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_data} !== {1'b1, 1'b0, 16'h0007}) begin
            n_fail++;
            $display("FAIL add_rsp: vld=%b id=%0d data=%h, required vld=1 id=0 data=0007",
                     o_rsp_valid, o_rsp_id, o_rsp_data);
        end
        step();
        @(negedge i_clk);
        n_tests++;
        if ({o_rsp_valid, o_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL add_done: vld=%b busy=%b, required 0 0", o_rsp_valid, o_busy);
        end
    endtask

    task automatic test_alternation();
        logic        ids [4];
        logic [15:0] dats[4];
        int          cnt;
        logic        exp_id;
        logic [15:0] exp_d;
        cnt = 0;
        do_reset();
        i_rsp_ready = 1'b1;
        i_req0_valid = 1'b1; i_req0_opcode = OP_SUB; i_req0_data1 = 16'h0000; i_req0_data2 = 16'h0001;
        i_req1_valid = 1'b1; i_req1_opcode = OP_XOR; i_req1_data1 = 16'hFF00; i_req1_data2 = 16'h0FF0;
        for (int i = 0; i < 40 && cnt < 4; i++) begin
            @(negedge i_clk);
            if (o_rsp_valid && i_rsp_ready) begin
                ids[cnt]  = o_rsp_id;
                dats[cnt] = o_rsp_data;
                cnt++;
            end
        end
        step();
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        n_tests++;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL alt_count: got %0d responses, required 4", cnt);
        end
        for (int k = 0; k < cnt; k++) begin
            exp_id = k[0];
            exp_d  = exp_id ? 16'hF0F0 : 16'hFFFF;
            n_tests++;
            if ({ids[k], dats[k]} !== {exp_id, exp_d}) begin
                n_fail++;
                $display("FAIL alt_rsp%0d: got id=%0d data=%h, required id=%0d data=%h",
                         k, ids[k], dats[k], exp_id, exp_d);
            end
        end
        wait_rsp_drain();
    endtask

    task automatic wait_rsp_drain();
        for (int i = 0; i < 10 && o_busy; i++) step();
    endtask

    task automatic test_shift();
        logic got;
        i_rsp_ready = 1'b1;
        send(1'b1, OP_SHIFT, 1'b1, 16'h0001, 16'h0004);
        wait_rsp(got);
        n_tests++;
        if ({got, o_rsp_id, o_rsp_data} !== {1'b1, 1'b1, 16'h0010}) begin
            n_fail++;
            $display("FAIL shift_left: got=%b id=%0d data=%h, required got=1 id=1 data=0010", got, o_rsp_id, o_rsp_data);
        end
        send(1'b1, OP_SHIFT, 1'b0, 16'h8000, 16'h0010);
        wait_rsp(got);
        n_tests++;
        if ({got, o_rsp_id, o_rsp_data} !== {1'b1, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL shift_right16: got=%b id=%0d data=%h, required got=1 id=1 data=0000", got, o_rsp_id, o_rsp_data);
        end
    endtask

    task automatic test_backpressure();
        logic got;
        send(1'b0, OP_ADD, 1'b0, 16'h1111, 16'h2222);
        i_rsp_ready = 1'b0;
        wait_rsp(got);
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL bp_rsp: no response within 20 cycles, required one");
        end
        for (int i = 0; i < 10; i++) begin
            step();
            i_req0_valid = 1'b1; i_req0_opcode = OP_SUB;
            i_req0_data1 = 16'($urandom); i_req0_data2 = 16'($urandom);
            i_req1_valid = 1'b1;
            @(negedge i_clk);
            n_tests++;
            if ({o_rsp_valid, o_rsp_id, o_rsp_data, o_req0_ready, o_req1_ready, o_busy}
                !== {1'b1, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: vld=%b id=%0d data=%h r0=%b r1=%b busy=%b, required 1 0 3333 0 0 1",
                         i, o_rsp_valid, o_rsp_id, o_rsp_data, o_req0_ready, o_req1_ready, o_busy);
            end
        end
        step();
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        i_rsp_ready  = 1'b1;
        @(negedge i_clk);
        step();
        @(negedge i_clk);
        n_tests++;
        if (o_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b after handshake, required 0", o_rsp_valid);
        end
    endtask

    task automatic test_reset_exec();
        logic got;
        logic seen;
        seen = 1'b0;
        send(1'b0, OP_ADD, 1'b0, 16'h0005, 16'h0006);
        i_reset = 1'b1;
        i_req0_valid = 1'b1;
        @(negedge i_clk);
        n_tests++;
        if ({o_req0_ready, o_req1_ready, o_rsp_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_exec_ready: r0=%b r1=%b vld=%b, required 0 0 0", o_req0_ready, o_req1_ready, o_rsp_valid);
        end
        step();
        i_reset = 1'b0;
        i_req0_valid = 1'b0;
        sb_q.delete();
        @(negedge i_clk);
        n_tests++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_data, o_busy} !== 19'h0) begin
            n_fail++;
            $display("FAIL rst_exec_out: vld=%b id=%0d data=%h busy=%b, required all zero",
                     o_rsp_valid, o_rsp_id, o_rsp_data, o_busy);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            if (o_rsp_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL rst_exec_norsp: rsp_valid seen after reset, required none");
        end
        send(1'b0, OP_ADD, 1'b0, 16'h0010, 16'h0020);
        wait_rsp(got);
        n_tests++;
        if ({got, o_rsp_id, o_rsp_data} !== {1'b1, 1'b0, 16'h0030}) begin
            n_fail++;
            $display("FAIL rst_exec_after: got=%b id=%0d data=%h, required 1 0 0030", got, o_rsp_id, o_rsp_data);
        end
    endtask

    task automatic test_halt();
        logic got;
        send(1'b1, OP_HALT, 1'b0, 16'h1234, 16'h5678);
        wait_rsp(got);
        n_tests++;
        if ({got, o_rsp_id, o_rsp_data} !== {1'b1, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL halt_rsp: got=%b id=%0d data=%h, required 1 1 0000", got, o_rsp_id, o_rsp_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step();
            i_rsp_ready      = ($urandom_range(0, 9) < 7);
            i_req0_valid     = $urandom_range(0, 1);
            i_req1_valid     = $urandom_range(0, 1);
            i_req0_opcode    = 4'($urandom);
            i_req1_opcode    = 4'($urandom);
            i_req0_shift_dir = $urandom_range(0, 1);
            i_req1_shift_dir = $urandom_range(0, 1);
            i_req0_data1     = 16'($urandom);
            i_req1_data1     = 16'($urandom);
            i_req0_data2     = $urandom_range(0, 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            i_req1_data2     = $urandom_range(0, 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
        end
        step();
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        i_rsp_ready  = 1'b1;
        wait_rsp_drain();
        step();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alternation();
        test_shift();
        test_backpressure();
        test_reset_exec();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; data width is fixed at 16 bits and opcode width at 4 bits.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_req0_valid / i_req1_valid  input  1  requester N presents an operation.
REQ-005 o_req0_ready / o_req1_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 i_req0_opcode / i_req1_opcode  input  4  ALU opcode from the shared opcode set.
REQ-007 i_req0_shift_dir / i_req1_shift_dir  input  1  0 = shift right, 1 = shift left.
REQ-008 i_req0_data1 / i_req1_data1, i_req0_data2 / i_req1_data2  input  16  operands.
REQ-009 o_rsp_valid  output  1  result available.
REQ-010 i_rsp_ready  input  1  consumer takes the result.
REQ-011 o_rsp_id  output  1  requester that owns the result (0 or 1).
REQ-012 o_rsp_data  output  16  ALU result.
REQ-013 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be exactly IDLE, EXEC and RESP.
REQ-015 IDLE grant rule: a single valid requester is granted; if both are valid, the requester not granted last is granted; if neither is valid, no grant.
REQ-016 o_reqN_ready SHALL be combinational: high only in IDLE and only for the granted requester; never high for both requesters.
REQ-017 Transfer occurs when valid && ready; on transfer, opcode, shift_dir, data1, data2 and the granted id SHALL be latched; next state is EXEC.
REQ-018 EXEC: latched operands drive the single ALU instance; the ALU output SHALL be registered into o_rsp_data and the id into o_rsp_id; next state is RESP.
REQ-019 RESP: o_rsp_valid = 1; o_rsp_data and o_rsp_id SHALL hold stable until i_rsp_ready = 1.
REQ-020 On the RESP handshake, the last-grant pointer SHALL update to o_rsp_id, o_rsp_valid SHALL drop the next cycle, and the FSM SHALL return to IDLE.
REQ-021 Latency: transfer in cycle N gives o_rsp_valid high in cycle N+2; minimum spacing between accepts is 3 cycles.
REQ-022 Results SHALL equal 16-bit ALU semantics: ADD/SUB wrap modulo 2^16; a SHIFT amount of 16 or more yields 0x0000; MOVE returns data1.
REQ-023 Opcodes with no ALU result (LOAD, STORE, JUMP, LOADC, OUT, UNDEF3, UNDEF4, HALT, NOP) SHALL still complete normally with o_rsp_data = 0x0000.
REQ-024 A requester dropping valid before it is granted SHALL be ignored; its inputs are not sampled outside the transfer cycle.
REQ-025 Requester inputs changing during EXEC or RESP SHALL not affect the in-flight result.
REQ-026 If i_rsp_ready is held low, RESP SHALL persist indefinitely, and both readies SHALL stay low.

Reset
REQ-027 On i_reset: state = IDLE, o_rsp_valid = 0, o_rsp_data = 0x0000, o_rsp_id = 0, o_busy = 0, and the last-grant pointer = 1, so requester 0 wins the first tie.
REQ-028 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response; o_reqN_ready SHALL be 0 during any cycle in which i_reset is high.

Structure
REQ-029 Opcode constants SHALL come from the existing shared opcode header; state encodings and requester id constants SHALL be local constants of this module.
REQ-030 Exactly one sub-module: the existing ALU module, instantiated once and fed only from latched registers.
REQ-031 Operand and result registers SHALL be 16 bits; no operation SHALL widen or sign-extend operands.

Verification
REQ-032 Req0 only, ADD 0x0003 + 0x0004, i_rsp_ready = 1 -> ready0 in the accept cycle; o_rsp_valid two cycles later with data 0x0007, id 0.
REQ-033 Both valid continuously after reset, req0 SUB 0x0000 - 0x0001, req1 XOR 0xFF00 ^ 0x0FF0 -> response sequence id0 0xFFFF, then id1 0xF0F0, then id0; strict alternation.
REQ-034 Req1 SHIFT left 0x0001 by 0x0004, then SHIFT right 0x8000 by 0x0010 -> results 0x0010 then 0x0000.
REQ-035 i_rsp_ready held low 10 cycles in RESP while req0 changes operands -> data and id stable, readies low, o_busy high; result released on the ready handshake.
REQ-036 i_reset pulsed in EXEC -> no o_rsp_valid; all outputs at reset values next cycle; a subsequent ADD completes normally.
REQ-037 Opcode HALT with operands 0x1234 / 0x5678 -> response with data 0x0000 and correct id.
